// File: rtl/sprite_path_mover_pkg.sv
// Shared definitions for the sprite path mover: FSM states, move directions
// and the bit layout of a path segment table entry.
// Segment entry layout, MSB first: {en, kind, c[X_W:0], xmin[X_W-1:0], xmax[X_W-1:0]}.
package sprite_path_mover_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_REJECT,
        ST_ERASE_REQ,
        ST_ERASE_WAIT,
        ST_UPDATE,
        ST_DRAW_REQ,
        ST_DRAW_WAIT
    } state_t;

    // bit0 set = step towards -x, bit1 set = step towards -y
    typedef enum logic [1:0] {
        DIR_PXPY = 2'd0,
        DIR_MXPY = 2'd1,
        DIR_PXMY = 2'd2,
        DIR_MXMY = 2'd3
    } dir_t;

    localparam logic KIND_ANTI = 1'b0;  // x + y == c
    localparam logic KIND_DIAG = 1'b1;  // x - y == c (wrapping)

    localparam int SEG_XMAX_LSB = 0;

    function automatic int seg_w(input int xw);
        return 3 * xw + 3;
    endfunction

    function automatic int seg_xmin_lsb(input int xw);
        return xw;
    endfunction

    function automatic int seg_c_lsb(input int xw);
        return 2 * xw;
    endfunction

    function automatic int seg_kind_bit(input int xw);
        return 3 * xw + 1;
    endfunction

    function automatic int seg_en_bit(input int xw);
        return 3 * xw + 2;
    endfunction

endpackage

// File: rtl/sprite_path_mover_if.sv
// Handshake/bus bundle between the direction logic, the path mover and the
// sprite drawer. Signal suffixes are from the path mover's point of view.
interface sprite_path_mover_if #(
    parameter int X_W     = 9,
    parameter int Y_W     = 8,
    parameter int NUM_SEG = 8
);
    localparam int IDX_W = $clog2(NUM_SEG);
    localparam int SEG_W = sprite_path_mover_pkg::seg_w(X_W);

    logic             move_i;
    logic [1:0]       dir_i;
    logic             seg_we_i;
    logic [IDX_W-1:0] seg_idx_i;
    logic [SEG_W-1:0] seg_data_i;
    logic             seg_ready_o;
    logic             done_bg_i;
    logic             done_char_i;
    logic             draw_bg_o;
    logic             draw_char_o;
    logic [X_W-1:0]   x_coord_o;
    logic [Y_W-1:0]   y_coord_o;
    logic             busy_o;
    logic             move_rejected_o;

    modport slave (
        input  move_i, dir_i, seg_we_i, seg_idx_i, seg_data_i, done_bg_i, done_char_i,
        output seg_ready_o, draw_bg_o, draw_char_o, x_coord_o, y_coord_o, busy_o,
               move_rejected_o
    );

    modport master (
        output move_i, dir_i, seg_we_i, seg_idx_i, seg_data_i, done_bg_i, done_char_i,
        input  seg_ready_o, draw_bg_o, draw_char_o, x_coord_o, y_coord_o, busy_o,
               move_rejected_o
    );
endinterface

// File: rtl/sprite_path_mover_path_seg_table.sv
// Runtime-loadable path segment table. Reset only clears the enable bits so
// the array itself needs no reset network; reads are combinational.
module path_seg_table
    import sprite_path_mover_pkg::*;
#(
    parameter int X_W     = 9,
    parameter int NUM_SEG = 8,
    localparam int IDX_W  = $clog2(NUM_SEG),
    localparam int SEG_W  = seg_w(X_W)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] widx_i,
    input  logic [SEG_W-1:0] wdata_i,
    input  logic [IDX_W-1:0] ridx_i,
    output logic [SEG_W-1:0] rdata_o
);
    localparam int EN_BIT = seg_en_bit(X_W);

    logic [NUM_SEG-1:0][SEG_W-1:0] tbl_q;

    // Write port; reset disables every entry but leaves its geometry alone
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_SEG; i++) begin
                tbl_q[i][EN_BIT] <= 1'b0;
            end
        end else if (we_i) begin
            tbl_q[widx_i] <= wdata_i;
        end
    end

    assign rdata_o = tbl_q[ridx_i];
endmodule

// File: rtl/sprite_path_mover.sv
// Sprite path mover: rate-limits diagonal move requests, scans the path
// segment table for the candidate position and sequences the drawer
// erase/update/draw handshake.
// Optional macro SPRITE_MOVE_QUEUE_EN: keeps one pending move captured while
// busy and starts it immediately on completion of the current one.
module sprite_path_mover
    import sprite_path_mover_pkg::*;
#(
    parameter int X_W      = 9,
    parameter int Y_W      = 8,
    parameter int NUM_SEG  = 8,
    parameter int STEP     = 1,
    parameter int TICK_DIV = 6250000,
    parameter int START_X  = 96,
    parameter int START_Y  = 222,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240
) (
    input logic                clock_i,
    input logic                reset_i,
    sprite_path_mover_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_SEG);
    localparam int SEG_W = seg_w(X_W);
    localparam int CW    = X_W + 2;
    localparam int TW    = $clog2(TICK_DIV + 1);
    localparam logic [X_W:0] STEP_X = (X_W+1)'(STEP);
    localparam logic [Y_W:0] STEP_Y = (Y_W+1)'(STEP);

    state_t           state_q;
    logic [X_W-1:0]   x_q;
    logic [Y_W-1:0]   y_q;
    logic [X_W:0]     cand_x_q;
    logic [Y_W:0]     cand_y_q;
    logic [IDX_W-1:0] chk_idx_q;
    logic             valid_q;
    logic             draw_bg_q;
    logic             draw_char_q;
    logic             rej_q;
    logic [TW-1:0]    tick_cnt_q;
    logic             tick;

    // Free-running move tick divider
    assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));
    always_ff @(posedge clock_i) begin
        if (reset_i || tick) tick_cnt_q <= '0;
        else                 tick_cnt_q <= tick_cnt_q + 1'b1;
    end

    dir_t dir_sel;
    logic pend_q;
`ifdef SPRITE_MOVE_QUEUE_EN
    dir_t pend_dir_q;
    assign dir_sel = pend_q ? pend_dir_q : dir_t'(bus.dir_i);
`else
    assign pend_q  = 1'b0;
    assign dir_sel = dir_t'(bus.dir_i);
`endif

    // Candidate carries one extra bit so under/overflow shows as the MSB
    logic [X_W:0] nx_d;
    logic [Y_W:0] ny_d;
    assign nx_d = dir_sel[0] ? ({1'b0, x_q} - STEP_X) : ({1'b0, x_q} + STEP_X);
    assign ny_d = dir_sel[1] ? ({1'b0, y_q} - STEP_Y) : ({1'b0, y_q} + STEP_Y);

    logic leave_busy, start_chk;
    assign leave_busy = (state_q == ST_REJECT) || (state_q == ST_DRAW_WAIT && bus.done_char_i);
    assign start_chk  = (state_q == ST_IDLE) ? (pend_q || (bus.move_i && tick))
                                             : (leave_busy && pend_q);

    logic [SEG_W-1:0] seg_rd;
    path_seg_table #(.X_W(X_W), .NUM_SEG(NUM_SEG)) u_tbl (
        .clk_i   (clock_i),
        .rst_i   (reset_i),
        .we_i    (bus.seg_we_i && state_q == ST_IDLE),
        .widx_i  (bus.seg_idx_i),
        .wdata_i (bus.seg_data_i),
        .ridx_i  (chk_idx_q),
        .rdata_o (seg_rd)
    );

    logic           seg_en, seg_kind, seg_hit, in_range, line_hit, off_screen;
    logic [X_W:0]   seg_c, diff;
    logic [X_W-1:0] seg_xmin, seg_xmax;
    logic [CW-1:0]  sum;
    assign seg_en     = seg_rd[seg_en_bit(X_W)];
    assign seg_kind   = seg_rd[seg_kind_bit(X_W)];
    assign seg_c      = seg_rd[seg_c_lsb(X_W) +: X_W+1];
    assign seg_xmin   = seg_rd[seg_xmin_lsb(X_W) +: X_W];
    assign seg_xmax   = seg_rd[SEG_XMAX_LSB +: X_W];
    assign sum        = CW'(cand_x_q) + CW'(cand_y_q);
    assign diff       = cand_x_q - (X_W+1)'(cand_y_q);
    assign in_range   = ({1'b0, seg_xmin} <= cand_x_q) && (cand_x_q <= {1'b0, seg_xmax});
    assign line_hit   = (seg_kind == KIND_DIAG) ? (diff == seg_c) : (sum == CW'(seg_c));
    assign seg_hit    = seg_en && line_hit && in_range;
    assign off_screen = cand_x_q[X_W] || cand_y_q[Y_W] || cand_x_q == '0 || cand_y_q == '0 ||
                        cand_x_q >= (X_W+1)'(SCREEN_W) || cand_y_q >= (Y_W+1)'(SCREEN_H);

    // Move sequencer with registered strobes and committed position
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            x_q         <= X_W'(START_X);
            y_q         <= Y_W'(START_Y);
            cand_x_q    <= '0;
            cand_y_q    <= '0;
            chk_idx_q   <= '0;
            valid_q     <= 1'b0;
            draw_bg_q   <= 1'b0;
            draw_char_q <= 1'b0;
            rej_q       <= 1'b0;
        end else begin
            draw_bg_q   <= 1'b0;
            draw_char_q <= 1'b0;
            rej_q       <= 1'b0;
            if (start_chk) begin
                state_q   <= ST_CHECK;
                cand_x_q  <= nx_d;
                cand_y_q  <= ny_d;
                chk_idx_q <= '0;
                valid_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: ;
                    ST_CHECK: begin
                        if (seg_hit) valid_q <= 1'b1;
                        if (chk_idx_q == IDX_W'(NUM_SEG - 1)) begin
                            if (!off_screen && (valid_q || seg_hit)) begin
                                state_q   <= ST_ERASE_REQ;
                                draw_bg_q <= 1'b1;
                            end else begin
                                state_q <= ST_REJECT;
                                rej_q   <= 1'b1;
                            end
                        end else begin
                            chk_idx_q <= chk_idx_q + 1'b1;
                        end
                    end
                    ST_REJECT:     state_q <= ST_IDLE;
                    ST_ERASE_REQ:  state_q <= ST_ERASE_WAIT;
                    ST_ERASE_WAIT: if (bus.done_bg_i) state_q <= ST_UPDATE;
                    ST_UPDATE: begin
                        x_q         <= cand_x_q[X_W-1:0];
                        y_q         <= cand_y_q[Y_W-1:0];
                        state_q     <= ST_DRAW_REQ;
                        draw_char_q <= 1'b1;
                    end
                    ST_DRAW_REQ:   state_q <= ST_DRAW_WAIT;
                    ST_DRAW_WAIT:  if (bus.done_char_i) state_q <= ST_IDLE;
                    default:       state_q <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef SPRITE_MOVE_QUEUE_EN
    // One-deep pending move: first request while busy wins, later ones drop
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            pend_q     <= 1'b0;
            pend_dir_q <= DIR_PXPY;
        end else if (start_chk && pend_q) begin
            pend_q <= 1'b0;
        end else if (state_q != ST_IDLE && bus.move_i && tick && !pend_q) begin
            pend_q     <= 1'b1;
            pend_dir_q <= dir_t'(bus.dir_i);
        end
    end
`endif

    assign bus.seg_ready_o     = (state_q == ST_IDLE);
    assign bus.busy_o          = (state_q != ST_IDLE);
    assign bus.draw_bg_o       = draw_bg_q;
    assign bus.draw_char_o     = draw_char_q;
    assign bus.move_rejected_o = rej_q;
    assign bus.x_coord_o       = x_q;
    assign bus.y_coord_o       = y_q;
endmodule

// File: tb/tb_sprite_path_mover.sv
// Self-checking bench for sprite_path_mover (TICK_DIV=4, NUM_SEG=8).
module tb_sprite_path_mover;
    localparam int NS = 8;
    localparam int TD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   tcnt = 0;

    // reference state: committed position and segment table
    int mx, my;
    int m_en[NS], m_kind[NS], m_c[NS], m_xmin[NS], m_xmax[NS];

    sprite_path_mover_if #(.X_W(9), .Y_W(8), .NUM_SEG(NS)) bus ();

    sprite_path_mover #(
        .X_W(9), .Y_W(8), .NUM_SEG(NS), .STEP(1), .TICK_DIV(TD),
        .START_X(96), .START_Y(222), .SCREEN_W(320), .SCREEN_H(240)
    ) dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // tick phase: tick occurs in the cycle where tcnt==TD-1
    always @(posedge clk) begin
        if (rst) tcnt <= 0;
        else     tcnt <= (tcnt == TD - 1) ? 0 : tcnt + 1;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog simulation did not finish checks=%0d", checks);
        $fatal(1);
    end

    function automatic bit model_ok(input int nx, input int ny);
        bit ok = 1'b0;
        if (nx <= 0 || ny <= 0 || nx >= 320 || ny >= 240) return 1'b0;
        for (int i = 0; i < NS; i++) begin
            if (m_en[i] != 0) begin
                int v = (m_kind[i] == 0) ? nx + ny : (((nx - ny) % 1024) + 1024) % 1024;
                if (v == m_c[i] && nx >= m_xmin[i] && nx <= m_xmax[i]) ok = 1'b1;
            end
        end
        return ok;
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        bus.move_i = 0; bus.dir_i = 0; bus.seg_we_i = 0; bus.seg_idx_i = 0;
        bus.seg_data_i = '0; bus.done_bg_i = 0; bus.done_char_i = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mx = 96; my = 222;
        for (int i = 0; i < NS; i++) m_en[i] = 0;
    endtask

    task automatic write_seg(input int idx, input int en, input int kind, input int c,
                             input int xmin, input int xmax);
        bus.seg_we_i   = 1'b1;
        bus.seg_idx_i  = 3'(idx);
        bus.seg_data_i = {1'(en), 1'(kind), 10'(c), 9'(xmin), 9'(xmax)};
        @(negedge clk);
        bus.seg_we_i = 1'b0;
        m_en[idx] = en; m_kind[idx] = kind; m_c[idx] = c; m_xmin[idx] = xmin; m_xmax[idx] = xmax;
    endtask

    task automatic do_move(input int d, input int wbg, input int wch, input bit inject_we);
        int nx, ny, cyc;
        bit exp_ok;
        nx = mx + (((d & 1) != 0) ? -1 : 1);
        ny = my + (((d & 2) != 0) ? -1 : 1);
        exp_ok = model_ok(nx, ny);
        bus.dir_i = 2'(d);
        bus.move_i = 1'b1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (bus.busy_o !== 1'b1 && cyc < 3 * TD);
        bus.move_i = 1'b0;
        checks++;
        if (bus.busy_o !== 1'b1 || tcnt != 0) begin
            failures++;
            $display("FAIL move_start busy=%0b tick_phase=%0d required busy=1 phase=0", bus.busy_o, tcnt);
            return;
        end
        cyc = 1;
        while (bus.draw_bg_o !== 1'b1 && bus.move_rejected_o !== 1'b1 && cyc < 4 * NS) begin
            @(negedge clk); cyc++;
        end
        checks++;
        if (cyc != NS + 1) begin
            failures++;
            $display("FAIL check_latency got=%0d required=%0d", cyc, NS + 1);
        end
        checks++;
        if (bus.draw_bg_o !== exp_ok || bus.move_rejected_o !== !exp_ok) begin
            failures++;
            $display("FAIL move_outcome cand=(%0d,%0d) draw_bg=%0b rejected=%0b required accept=%0b",
                     nx, ny, bus.draw_bg_o, bus.move_rejected_o, exp_ok);
        end
        if (bus.draw_bg_o !== 1'b1) begin
            checks++;
            if (bus.x_coord_o !== 9'(mx) || bus.y_coord_o !== 8'(my) || bus.draw_char_o !== 1'b0) begin
                failures++;
                $display("FAIL reject_pos x=%0d y=%0d draw_char=%0b required x=%0d y=%0d draw_char=0",
                         bus.x_coord_o, bus.y_coord_o, bus.draw_char_o, mx, my);
            end
            @(negedge clk);
            checks++;
            if (bus.busy_o !== 1'b0 || bus.move_rejected_o !== 1'b0) begin
                failures++;
                $display("FAIL reject_end busy=%0b rejected=%0b required 0 0", bus.busy_o, bus.move_rejected_o);
            end
            return;
        end
        bus.done_bg_i = 1'b1;            // lands in the request cycle, must be ignored
        @(negedge clk);
        bus.done_bg_i = 1'b0;
        if (inject_we) begin
            bus.seg_we_i = 1'b1; bus.seg_idx_i = 3'd0; bus.seg_data_i = '0;
        end
        repeat (wbg) begin @(negedge clk); bus.seg_we_i = 1'b0; end
        checks++;
        if (bus.busy_o !== 1'b1 || bus.seg_ready_o !== 1'b0 || bus.draw_bg_o !== 1'b0 ||
            bus.draw_char_o !== 1'b0 || bus.x_coord_o !== 9'(mx) || bus.y_coord_o !== 8'(my)) begin
            failures++;
            $display("FAIL erase_wait busy=%0b ready=%0b bg=%0b ch=%0b x=%0d y=%0d required 1 0 0 0 %0d %0d",
                     bus.busy_o, bus.seg_ready_o, bus.draw_bg_o, bus.draw_char_o,
                     bus.x_coord_o, bus.y_coord_o, mx, my);
        end
        bus.done_bg_i = 1'b1;
        cyc = 0;
        do begin @(negedge clk); bus.done_bg_i = 1'b0; cyc++; end
        while (bus.draw_char_o !== 1'b1 && cyc < 10);
        checks++;
        if (cyc != 2 || bus.x_coord_o !== 9'(nx) || bus.y_coord_o !== 8'(ny)) begin
            failures++;
            $display("FAIL draw_req cycles=%0d x=%0d y=%0d required cycles=2 x=%0d y=%0d",
                     cyc, bus.x_coord_o, bus.y_coord_o, nx, ny);
        end
        bus.done_char_i = 1'b1;          // request cycle, ignored
        @(negedge clk);
        bus.done_char_i = 1'b0;
        repeat (wch) @(negedge clk);
        checks++;
        if (bus.busy_o !== 1'b1 || bus.draw_char_o !== 1'b0) begin
            failures++;
            $display("FAIL draw_wait busy=%0b draw_char=%0b required 1 0", bus.busy_o, bus.draw_char_o);
        end
        bus.done_char_i = 1'b1;
        @(negedge clk);
        bus.done_char_i = 1'b0;
        checks++;
        if (bus.busy_o !== 1'b0 || bus.x_coord_o !== 9'(nx) || bus.y_coord_o !== 8'(ny)) begin
            failures++;
            $display("FAIL move_done busy=%0b x=%0d y=%0d required 0 %0d %0d",
                     bus.busy_o, bus.x_coord_o, bus.y_coord_o, nx, ny);
        end
        mx = nx; my = ny;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (bus.x_coord_o !== 9'd96 || bus.y_coord_o !== 8'd222) begin
            failures++;
            $display("FAIL reset_pos x=%0d y=%0d required 96 222", bus.x_coord_o, bus.y_coord_o);
        end
        checks++;
        if (bus.busy_o !== 1'b0 || bus.seg_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_status busy=%0b ready=%0b required 0 1", bus.busy_o, bus.seg_ready_o);
        end
        checks++;
        if (bus.draw_bg_o !== 1'b0 || bus.draw_char_o !== 1'b0 || bus.move_rejected_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_strobes bg=%0b ch=%0b rej=%0b required 0 0 0",
                     bus.draw_bg_o, bus.draw_char_o, bus.move_rejected_o);
        end
    endtask

    task automatic test_basic_move();
        apply_reset();
        write_seg(0, 1, 0, 318, 96, 122);
        do_move(3, 1, 1, 1'b0);          // (95,221): sum 316, rejected
        do_move(2, 3, 2, 1'b0);          // (97,221): accepted
    endtask

    task automatic test_we_drop();
        apply_reset();
        write_seg(0, 1, 0, 318, 96, 122);
        do_move(2, 2, 1, 1'b1);          // write attempt in ERASE_WAIT must be lost
        do_move(2, 1, 1, 1'b0);          // still accepted by the original entry
    endtask

    task automatic test_origin();
        apply_reset();
        write_seg(0, 1, 0, 318, 96, 159);
        write_seg(1, 1, 1, 0, 0, 159);
        for (int i = 0; i < 63; i++) do_move(2, 1, 1, 1'b0);
        for (int i = 0; i < 158; i++) do_move(3, 1, 1, 1'b0);
        do_move(3, 1, 1, 1'b0);          // (0,0) is on the diagonal but off screen
    endtask

    task automatic test_reset_mid_draw();
        int cyc;
        apply_reset();
        write_seg(0, 1, 0, 318, 96, 122);
        bus.dir_i = 2'd2; bus.move_i = 1'b1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (bus.draw_bg_o !== 1'b1 && cyc < 40);
        bus.move_i = 1'b0;
        @(negedge clk);
        bus.done_bg_i = 1'b1;
        cyc = 0;
        do begin @(negedge clk); bus.done_bg_i = 1'b0; cyc++; end while (bus.draw_char_o !== 1'b1 && cyc < 10);
        @(negedge clk);                  // DRAW_WAIT
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mx = 96; my = 222;
        for (int i = 0; i < NS; i++) m_en[i] = 0;
        checks++;
        if (bus.busy_o !== 1'b0 || bus.x_coord_o !== 9'd96 || bus.y_coord_o !== 8'd222) begin
            failures++;
            $display("FAIL reset_mid busy=%0b x=%0d y=%0d required 0 96 222",
                     bus.busy_o, bus.x_coord_o, bus.y_coord_o);
        end
        bus.done_char_i = 1'b1;
        @(negedge clk);
        bus.done_char_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy_o !== 1'b0 || bus.draw_char_o !== 1'b0 || bus.x_coord_o !== 9'd96) begin
            failures++;
            $display("FAIL stale_done busy=%0b draw_char=%0b x=%0d required 0 0 96",
                     bus.busy_o, bus.draw_char_o, bus.x_coord_o);
        end
        do_move(2, 1, 1, 1'b0);          // table was disabled by reset: rejected
    endtask

    task automatic test_random();
        apply_reset();
        for (int it = 0; it < 40; it++) begin
            int d, nx, ny, idx, kind, c, lo, hi;
            d   = $urandom_range(0, 3);
            idx = $urandom_range(0, NS - 1);
            nx  = mx + (((d & 1) != 0) ? -1 : 1);
            ny  = my + (((d & 2) != 0) ? -1 : 1);
            if ($urandom_range(0, 1) == 1) begin
                kind = $urandom_range(0, 1);
                c    = (kind == 0) ? nx + ny : (((nx - ny) % 1024) + 1024) % 1024;
                lo   = nx - $urandom_range(0, 3);
                hi   = nx + $urandom_range(0, 3);
                if ($urandom_range(0, 3) == 0) lo = nx + 1;
                if (lo < 0) lo = 0;
                if (hi > 511) hi = 511;
                write_seg(idx, 1, kind, c, lo, hi);
            end else begin
                write_seg(idx, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1023),
                          $urandom_range(0, 511), $urandom_range(0, 511));
            end
            do_move(d, $urandom_range(1, 4), $urandom_range(1, 4), 1'b0);
        end
    endtask

`ifdef SPRITE_MOVE_QUEUE_EN
    task automatic test_queue();
        int bg_cnt, drops, cyc;
        bit prev_busy;
        apply_reset();
        write_seg(0, 1, 0, 318, 96, 122);
        bus.dir_i = 2'd2; bus.move_i = 1'b1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (bus.draw_bg_o !== 1'b1 && cyc < 40);
        bg_cnt = 1;
        repeat (3 * TD) @(negedge clk);  // two+ ticks of requests while waiting on erase
        bus.move_i = 1'b0;
        bus.done_bg_i = 1'b1; bus.done_char_i = 1'b1;
        drops = 0; prev_busy = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus.draw_bg_o === 1'b1) bg_cnt++;
            if (prev_busy && bus.busy_o === 1'b0) drops++;
            prev_busy = bus.busy_o;
        end
        bus.done_bg_i = 1'b0; bus.done_char_i = 1'b0;
        checks++;
        if (bg_cnt != 2 || drops != 1 || bus.x_coord_o !== 9'd98 || bus.y_coord_o !== 8'd220) begin
            failures++;
            $display("FAIL queue moves=%0d idle_entries=%0d x=%0d y=%0d required 2 1 98 220",
                     bg_cnt, drops, bus.x_coord_o, bus.y_coord_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_move();
        test_we_drop();
        test_reset_mid_draw();
        test_random();
        test_origin();
`ifdef SPRITE_MOVE_QUEUE_EN
        test_queue();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
